// File: rtl/mem_ctrl.sv
// mem_ctrl: SPI master moving one byte between the control unit and the off-chip flash (PC) or RAM (MAR).
// Latency: done in cycle 2*(16+ADDR_WIDTH)+1 after the accept edge (cycle 65 at ADDR_WIDTH=16); cycle 1 for an illegal flash write or a cache hit.
// Backpressure: one request in flight; requests are only taken in IDLE, and never on the edge where mem_op_done is high.
// Optional feature macro: MEM_CTRL_READ_CACHE_EN (one-entry read cache; absent by default).
// Ports:
//   clock, reset                : system clock, asynchronous active-high reset
//   mem_ctrl_op, addr_sel       : request (1 = read, 2 = write, 0/3 = nop) and target (0 = flash, 1 = RAM)
//   addr, data_in               : byte address and write data, latched on accept
//   data_out, mem_op_done       : last byte read, one-cycle completion pulse
//   spi_sclk, spi_mosi, spi_miso: SPI mode 0 bus
//   spi_flash_cs_n, spi_ram_cs_n: active-low chip selects
module mem_ctrl #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_BUS_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                mem_ctrl_op,
   input  logic                      addr_sel,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_BUS_WIDTH-1:0] data_in,
   output logic [DATA_BUS_WIDTH-1:0] data_out,
   output logic                      mem_op_done,
   output logic                      spi_sclk,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output logic                      spi_flash_cs_n,
   output logic                      spi_ram_cs_n
);

   localparam int FRAME_BITS = 8 + ADDR_WIDTH + DATA_BUS_WIDTH;
   localparam int CW         = $clog2(FRAME_BITS);

   localparam logic [CW-1:0] LAST_CMD  = CW'(7);
   localparam logic [CW-1:0] LAST_ADDR = CW'(7 + ADDR_WIDTH);
   localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);

   localparam logic [1:0] OP_READ   = 2'd1;
   localparam logic [1:0] OP_WRITE  = 2'd2;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

   state_t state;
   state_t state_nxt;

   logic                      tgt;        // latched target: 0 = flash, 1 = RAM
   logic                      is_read;    // latched op
   logic [FRAME_BITS-1:0]     shreg;      // {command, address, write data}; MSB drives MOSI
   logic                      phase;      // 0 = low half of the bit, 1 = high half
   logic [CW-1:0]             bit_cnt;
   logic [DATA_BUS_WIDTH-2:0] rx_sr;      // read bits collected so far; the last one comes straight off MISO

   logic                      req;
   logic                      illegal;
   logic                      hit;
   logic                      start_spi;
   logic                      spi_active;
   logic                      bit_end;
   logic                      rd_last;
   logic [DATA_BUS_WIDTH-1:0] rx_byte;
   logic [DATA_BUS_WIDTH-1:0] hit_dat;

   // mem_op_done is only ever high in DONE, so restricting acceptance to IDLE
   // already keeps the request that is still present on the done edge from being taken.
   assign req        = (state == S_IDLE) &&
                       ((mem_ctrl_op == OP_READ) || (mem_ctrl_op == OP_WRITE));
   assign illegal    = (mem_ctrl_op == OP_WRITE) && !addr_sel;
   assign start_spi  = req && !illegal && !hit;
   assign spi_active = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
   assign bit_end    = spi_active && phase;
   assign rd_last    = bit_end && (bit_cnt == LAST_BIT) && is_read;
   assign rx_byte    = {rx_sr, spi_miso};

`ifdef MEM_CTRL_READ_CACHE_EN
   logic                      cache_vld;
   logic                      cache_tgt;
   logic [ADDR_WIDTH-1:0]     cache_addr;
   logic [DATA_BUS_WIDTH-1:0] cache_dat;

   assign hit     = (mem_ctrl_op == OP_READ) && cache_vld &&
                    (cache_tgt == addr_sel) && (cache_addr == addr);
   assign hit_dat = cache_dat;

   // The tag is captured when a read miss starts, which also drops valid until
   // the byte arrives; an abandoned read therefore never leaves a stale hit behind.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cache_vld  <= 1'b0;
         cache_tgt  <= 1'b0;
         cache_addr <= '0;
         cache_dat  <= '0;
      end else begin
         if (req && (mem_ctrl_op == OP_WRITE)) begin
            cache_vld <= 1'b0;
         end else if (start_spi) begin
            cache_vld  <= 1'b0;
            cache_tgt  <= addr_sel;
            cache_addr <= addr;
         end else if (rd_last) begin
            cache_vld <= 1'b1;
            cache_dat <= rx_byte;
         end
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_dat = '0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and bus outputs
   always_comb begin
      state_nxt      = state;
      mem_op_done    = 1'b0;
      spi_sclk       = 1'b0;
      spi_mosi       = 1'b0;
      spi_flash_cs_n = 1'b1;
      spi_ram_cs_n   = 1'b1;

      if (spi_active) begin
         spi_sclk       = phase;
         spi_mosi       = shreg[FRAME_BITS-1];
         spi_flash_cs_n = tgt;
         spi_ram_cs_n   = !tgt;
      end

      case (state)
         S_IDLE: begin
            if (req) begin
               state_nxt = (illegal || hit) ? S_DONE : S_CMD;
            end
         end
         S_CMD: begin
            if (bit_end && (bit_cnt == LAST_CMD)) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (bit_end && (bit_cnt == LAST_ADDR)) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_cnt == LAST_BIT)) state_nxt = S_DONE;
         end
         S_DONE: begin
            mem_op_done = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Serial datapath
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tgt      <= 1'b0;
         is_read  <= 1'b0;
         shreg    <= '0;
         phase    <= 1'b0;
         bit_cnt  <= '0;
         rx_sr    <= '0;
         data_out <= '0;
      end else begin
         if (state == S_IDLE) begin
            phase   <= 1'b0;
            bit_cnt <= '0;
            if (start_spi) begin
               tgt     <= addr_sel;
               is_read <= (mem_ctrl_op == OP_READ);
               // Read frames pad the data slot with zeros so MOSI idles low while MISO is shifted in.
               shreg   <= (mem_ctrl_op == OP_READ) ? {CMD_READ, addr, {DATA_BUS_WIDTH{1'b0}}}
                                                   : {CMD_WRITE, addr, data_in};
            end
            if (req && hit) begin
               data_out <= hit_dat;
            end
         end else if (spi_active) begin
            phase <= ~phase;
            // The edge closing the high half samples MISO and advances MOSI to the next bit.
            if (phase) begin
               rx_sr   <= rx_byte[DATA_BUS_WIDTH-2:0];
               shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
               bit_cnt <= bit_cnt + CW'(1);
               if (rd_last) begin
                  data_out <= rx_byte;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector bench for mem_ctrl with a byte-serving SPI slave model.
// Latency: checks done cycle, chip-select span, SCLK pattern and MOSI frame per transaction.
// Backpressure: requests are issued one at a time, each after the previous done has cleared.
module tb_mem_ctrl;

   logic        clock;
   logic        reset;
   logic [1:0]  mem_ctrl_op;
   logic        addr_sel;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        mem_op_done;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_flash_cs_n;
   logic        spi_ram_cs_n;

   mem_ctrl #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_ctrl_op    (mem_ctrl_op),
      .addr_sel       (addr_sel),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .mem_op_done    (mem_op_done),
      .spi_sclk       (spi_sclk),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_flash_cs_n (spi_flash_cs_n),
      .spi_ram_cs_n   (spi_ram_cs_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Results of the last transaction observed by txn
   int          r_done;
   int          r_fl;
   int          r_ram;
   int          r_first;
   int          r_last;
   int          r_nbits;
   int          r_sclk_bad;
   logic [31:0] r_frame;

   // Issues one request at a negedge, treats the following posedge as edge 0,
   // then watches cycles 1..limit at each negedge, acting as the SPI slave.
   task automatic txn(input logic [1:0] op, input logic sel, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] mrx, input bit hold, input int limit);
      bit act;
      bit exp_sclk;
      int b;
      r_done = 0; r_fl = 0; r_ram = 0; r_first = 0; r_last = 0;
      r_nbits = 0; r_sclk_bad = 0; r_frame = '0;
      @(negedge clock);
      mem_ctrl_op = op; addr_sel = sel; addr = a; data_in = d;
      @(posedge clock);
      #1;
      if (!hold) begin
         // Scramble the inputs: the running transaction must use its latched copies.
         mem_ctrl_op = 2'd0; addr_sel = ~sel; addr = 16'hFFFF; data_in = 8'hFF;
      end
      for (int c = 1; c <= limit; c++) begin
         @(negedge clock);
         act = !spi_flash_cs_n || !spi_ram_cs_n;
         if (!spi_flash_cs_n) r_fl++;
         if (!spi_ram_cs_n) r_ram++;
         if (act) begin
            if (r_first == 0) r_first = c;
            r_last = c;
         end
         exp_sclk = act && (c % 2 == 0);
         if (spi_sclk !== exp_sclk) r_sclk_bad++;
         if (act && spi_sclk) begin
            r_frame = {r_frame[30:0], spi_mosi};
            r_nbits++;
         end
         if (act && (c % 2 == 1)) begin
            b = (c - 1) / 2;
            spi_miso = (b >= 24 && b < 32) ? mrx[31-b] : 1'b0;
         end
         if (mem_op_done) begin
            r_done = c;
            break;
         end
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic        sel;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  mrx;
      bit          hold;
      int          e_done;
      logic [31:0] e_frame;
      int          e_fl;
      int          e_ram;
      logic [7:0]  e_dout;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'd1, 1'b0, 16'h0123, 8'h00, 8'hA5, 1'b0, 65, 32'h03012300, 64, 0, 8'hA5};
      vecs[1] = '{2'd2, 1'b1, 16'h0040, 8'h3C, 8'h00, 1'b0, 65, 32'h0200403C, 0, 64, 8'hA5};
      vecs[2] = '{2'd2, 1'b0, 16'h1234, 8'h55, 8'h00, 1'b0, 1,  32'h00000000, 0, 0,  8'hA5};
      vecs[3] = '{2'd1, 1'b1, 16'h00F0, 8'h00, 8'h5A, 1'b0, 65, 32'h0300F000, 0, 64, 8'h5A};
      vecs[4] = '{2'd3, 1'b1, 16'h0040, 8'h00, 8'h00, 1'b1, 0,  32'h00000000, 0, 0,  8'h5A};
      vecs[5] = '{2'd1, 1'b0, 16'h8001, 8'h00, 8'h81, 1'b0, 65, 32'h03800100, 64, 0, 8'h81};
      vecs[6] = '{2'd1, 1'b1, 16'h0010, 8'h00, 8'h77, 1'b0, 65, 32'h03001000, 0, 64, 8'h77};
`ifdef MEM_CTRL_READ_CACHE_EN
      vecs[7] = '{2'd1, 1'b1, 16'h0010, 8'h00, 8'h77, 1'b0, 1,  32'h00000000, 0, 0,  8'h77};
`else
      vecs[7] = '{2'd1, 1'b1, 16'h0010, 8'h00, 8'h77, 1'b0, 65, 32'h03001000, 0, 64, 8'h77};
`endif
      vecs[8] = '{2'd2, 1'b1, 16'h0010, 8'h11, 8'h00, 1'b0, 65, 32'h02001011, 0, 64, 8'h77};
      vecs[9] = '{2'd1, 1'b1, 16'h0010, 8'h00, 8'h11, 1'b0, 65, 32'h03001000, 0, 64, 8'h11};

      reset = 1'b1; mem_ctrl_op = 2'd0; addr_sel = 1'b0; addr = '0; data_in = '0; spi_miso = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_done", mem_op_done, 0);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_flash_cs_n", spi_flash_cs_n, 1);
      chk("rst_ram_cs_n", spi_ram_cs_n, 1);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 10; i++) begin
         txn(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].d, vecs[i].mrx, vecs[i].hold, 80);
         mem_ctrl_op = 2'd0;
         chk($sformatf("v%0d_done_cycle", i), r_done, vecs[i].e_done);
         chk($sformatf("v%0d_flash_cs_cycles", i), r_fl, vecs[i].e_fl);
         chk($sformatf("v%0d_ram_cs_cycles", i), r_ram, vecs[i].e_ram);
         chk($sformatf("v%0d_sclk_pattern_errors", i), r_sclk_bad, 0);
         chk($sformatf("v%0d_bits", i), r_nbits, (vecs[i].e_fl + vecs[i].e_ram) / 2);
         chk($sformatf("v%0d_data_out", i), data_out, vecs[i].e_dout);
         if (vecs[i].e_fl + vecs[i].e_ram == 64) begin
            chk($sformatf("v%0d_cs_first", i), r_first, 1);
            chk($sformatf("v%0d_cs_last", i), r_last, 64);
            chk($sformatf("v%0d_mosi_cmd_addr", i), r_frame[31:8], vecs[i].e_frame[31:8]);
            if (vecs[i].op == 2'd2)
               chk($sformatf("v%0d_mosi_wdata", i), r_frame[7:0], vecs[i].e_frame[7:0]);
         end
      end

      // Read held through its done cycle, then switched to a write.
      txn(2'd1, 1'b0, 16'h0200, 8'h00, 8'hC3, 1'b1, 80);
      chk("held_done_cycle", r_done, 65);
      chk("held_data_out", data_out, 8'hC3);
      @(negedge clock);
      chk("held_no_restart_flash_cs", spi_flash_cs_n, 1);
      chk("held_no_restart_ram_cs", spi_ram_cs_n, 1);
      chk("held_done_single", mem_op_done, 0);
      mem_ctrl_op = 2'd2; addr_sel = 1'b1; addr = 16'h0050; data_in = 8'h99;
      @(posedge clock);
      #1 mem_ctrl_op = 2'd0;
      @(negedge clock);
      chk("held_write_cs_two_after_done", spi_ram_cs_n, 0);
      begin
         int wd = 0;
         for (int c = 2; c <= 80; c++) begin
            @(negedge clock);
            if (mem_op_done) begin
               wd = c;
               break;
            end
         end
         chk("held_write_done_cycle", wd, 65);
      end
      chk("held_write_data_out", data_out, 8'hC3);

      // Reset in the middle of a RAM read.
      @(negedge clock);
      mem_ctrl_op = 2'd1; addr_sel = 1'b1; addr = 16'h0022;
      @(posedge clock);
      #1 mem_ctrl_op = 2'd0;
      repeat (20) @(negedge clock);
      chk("midrst_pre_ram_cs", spi_ram_cs_n, 0);
      chk("midrst_pre_sclk", spi_sclk, 1);
      reset = 1'b1;
      #1;
      chk("midrst_ram_cs", spi_ram_cs_n, 1);
      chk("midrst_flash_cs", spi_flash_cs_n, 1);
      chk("midrst_sclk", spi_sclk, 0);
      chk("midrst_mosi", spi_mosi, 0);
      chk("midrst_data_out", data_out, 8'h00);
      @(negedge clock);
      reset = 1'b0;
      begin
         int nd = 0;
         int ncs = 0;
         for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (mem_op_done) nd++;
            if (!spi_ram_cs_n || !spi_flash_cs_n) ncs++;
         end
         chk("midrst_no_done", nd, 0);
         chk("midrst_no_cs", ncs, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

SPI memory controller between the control unit and the off-chip program flash and data RAM. It accepts one byte-wide read or write request at a time from the control unit's `mem_ctrl_op` / `addr_sel` outputs and runs a serial transaction on the shared SPI bus. It returns the read byte on `data_out`, which the bus mux forwards to the control unit as `bus_data_in`, and pulses `mem_op_done` when the request finishes.

## Interface
Parameters:
- `ADDR_WIDTH`, 16 — address bits sent MSB-first after the command byte; must be a multiple of 8.
- `DATA_BUS_WIDTH`, 8 — data width; fixed at 8.

Ports:
- `clock`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_ctrl_op`  in  2  request: 0 = MEM_NOP, 1 = MEM_READ, 2 = MEM_WRITE, 3 = treated as MEM_NOP.
- `addr_sel`  in  1  target: 0 = PC → flash, 1 = MAR → RAM.
- `addr`  in  ADDR_WIDTH  byte address from the selected address register.
- `data_in`  in  8  write data (ALU pass-through).
- `data_out`  out  8  last byte read.
- `mem_op_done`  out  1  one-cycle completion pulse.
- `spi_sclk`  out  1  SPI clock, mode 0.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.
- `spi_flash_cs_n`  out  1  flash chip select, active low.
- `spi_ram_cs_n`  out  1  RAM chip select, active low.

## Operation
- States: IDLE, CMD, ADDR, DATA, DONE.
- **IDLE → CMD.** In IDLE, a request is accepted on a rising edge when `mem_ctrl_op` is READ or WRITE and `mem_op_done` is 0. The op is ignored on the edge where done is high, because the control unit reacts to done one cycle late.
- **Latching.** On acceptance, latch op, target, `addr` and `data_in`. Later changes to these inputs have no effect on the running transaction.
- **Flash write.** A WRITE with `addr_sel` = 0 is illegal. It produces no SPI activity, goes straight to DONE, and leaves `data_out` unchanged.
- **Command byte.** READ = 0x03, WRITE = 0x02, sent MSB-first.
- **Address.** ADDR_WIDTH bits, MSB-first.
- **DATA phase.** READ shifts 8 bits in from MISO, MSB-first. WRITE shifts the 8 latched `data_in` bits out.
- **Bit timing.** Each bit takes 2 clocks:
  - low half: `spi_sclk` = 0 and MOSI is updated;
  - high half: `spi_sclk` = 1;
  - MISO is sampled on the clock edge that ends the high half.
- **Chip selects.** Only the latched target's CS is driven low, for the whole CMD, ADDR and DATA span. Both are high in IDLE and DONE.
- **DONE.** Lasts exactly one cycle:
  - `mem_op_done` = 1;
  - `data_out` already holds the new byte on a read;
  - then return to IDLE.
- **data_out hold.** `data_out` keeps its value until the next read completes.

## Timing
- **Reset values.** `data_out` = 0x00, `mem_op_done` = 0, `spi_sclk` = 0, `spi_mosi` = 0, both CS_n = 1, state = IDLE, cache invalid.
- **Reset mid-transaction.** Same values, applied immediately (asynchronous); the transaction is abandoned with no done pulse.
- **Latency.** With acceptance edge = edge 0:
  - CS_n is low in cycles 1 … 2·(16+ADDR_WIDTH);
  - `mem_op_done` is high in cycle 2·(16+ADDR_WIDTH)+1, which is cycle 65 for ADDR_WIDTH = 16.
- **Illegal flash write.** Done in cycle 1.
- **Back-to-back requests.** A new request is accepted at the earliest on the edge ending the cycle after done, giving a minimum of one idle cycle between transactions. A change from READ to WRITE directly at done is legal.
- **Throughput.** One transaction in flight; no queuing.

## Configuration
`MEM_CTRL_READ_CACHE_EN`:
- **Defined:** a one-entry cache holds the last read's {target, addr, data} plus a valid bit.
  - A READ accepted with matching target and addr and valid = 1 skips SPI and goes straight to DONE (done in cycle 1). `data_out` is reloaded from the cache entry, which equals the held `data_out` value.
  - A completed READ refills the entry.
  - Any accepted WRITE clears valid.
- **Undefined:** no cache state; every read runs the full SPI transaction.

## Test plan
- **Flash read.** READ, `addr_sel` = 0, `addr` = 0x0123, MISO model returns 0xA5 → MOSI carries 0x03, 0x01, 0x23; `spi_flash_cs_n` low for cycles 1–64, `spi_ram_cs_n` stays high; `mem_op_done` high only in cycle 65; `data_out` = 0xA5.
- **RAM write.** WRITE, `addr_sel` = 1, `addr` = 0x0040, `data_in` = 0x3C → MOSI carries 0x02, 0x00, 0x40, 0x3C on `spi_ram_cs_n`; `data_out` is unchanged.
- **Op held through done.** READ held through the done cycle, then switched to WRITE → no transaction starts on the done edge; the write's CS falls exactly 2 cycles after done.
- **Illegal flash write.** WRITE with `addr_sel` = 0 → no CS activity, done in cycle 1.
- **Reset mid-read.** `reset` asserted at cycle 20 of a read → CS_n = 1, `spi_sclk` = 0, `data_out` = 0x00 in the same cycle; no done pulse follows.
- **Cache.** Two reads of RAM 0x0010 (data 0x77) → with `MEM_CTRL_READ_CACHE_EN` the second completes in cycle 1 with no CS and `data_out` = 0x77; without it, the second completes in cycle 65. With the macro, a write between the two reads forces a full 65-cycle second read.
